bcm_scan_controller: RTL and testbench
======================================

Name: bcm_scan_controller

Overview:
- Sequences the per-pixel RGB565 split/brightness datapath for a HUB75-style panel using binary-coded modulation.
- For each scan row and each bit plane, it does the following in order:
  - shifts one row of pixels out;
  - blanks the panel;
  - latches the row;
  - holds output enable for a time weighted by plane significance.
- Drives the one-hot brightness mask, the per-channel rgb enable, the framebuffer column/row address, and the panel control strobes.

Parameters:
- PIXELS_PER_ROW, 64, pixels shifted per row per plane.
- SCAN_ROWS, 16, multiplexed scan rows; row_address width is clog2(SCAN_ROWS).
- BITPLANES, 6, brightness bit planes; equals the brightness_mask width.
- BASE_ON_CYCLES, 4, display cycles for plane 0; plane p displays BASE_ON_CYCLES << p cycles.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled in IDLE and at frame end.
- column_address  out  clog2(PIXELS_PER_ROW)  pixel index being presented to the datapath.
- row_address  out  clog2(SCAN_ROWS)  panel row select / framebuffer row.
- brightness_mask  out  BITPLANES  one-hot current plane, LSB = plane 0.
- rgb_enable  out  3  channel enables to the split datapath; all ones while shifting, else 0.
- pixel_clock  out  1  panel shift clock.
- row_latch  out  1  panel latch strobe.
- output_enable_n  out  1  panel OE, active low.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last display period of a frame.

Behaviour:
- Reset state: IDLE; column_address=0, row_address=0, brightness_mask=1 (plane 0), rgb_enable=0, pixel_clock=0, row_latch=0, output_enable_n=1, busy=0, frame_done=0.
- All outputs are registered.
- States and transitions:
  - IDLE -> SHIFT when enable=1.
  - SHIFT -> BLANK -> LATCH -> DISPLAY.
  - DISPLAY -> SHIFT, or -> IDLE at frame end with enable=0.
- SHIFT:
  - Lasts 2 cycles per pixel, 2*PIXELS_PER_ROW cycles total.
  - Phase 0: column_address holds the pixel index and pixel_clock=0. Phase 1: pixel_clock=1.
  - column_address increments after phase 1.
  - After the last pixel, column_address wraps to 0 on the same edge as entering BLANK.
  - output_enable_n=1 throughout; rgb_enable=3'b111.
- BLANK:
  - 1 cycle; output_enable_n=1, rgb_enable=0, pixel_clock=0.
  - row_address is loaded with the current scan row here, so it only changes while the panel is dark.
- LATCH:
  - 1 cycle; row_latch=1 and output_enable_n=1.
- DISPLAY:
  - Lasts BASE_ON_CYCLES << plane cycles; output_enable_n=0 for exactly that many cycles.
  - Down-counter width is clog2(BASE_ON_CYCLES << (BITPLANES-1)) + 1, with no overflow.
- Advance on the last DISPLAY cycle:
  - plane increments and brightness_mask shifts left by 1.
  - If plane == BITPLANES-1: the mask returns to 1 and the scan row increments.
  - If the scan row also wraps from SCAN_ROWS-1 to 0: frame_done=1 for one cycle, coincident with entering the next state.
- Frame end:
  - enable=1: continue straight into SHIFT with no idle cycle.
  - enable=0: go to IDLE with row_address=0 and mask=1.
- Mid-frame enable deassertion is ignored; the frame always completes so every row receives equal on-time.
- Plane order is LSB first (0..BITPLANES-1) within each row; all planes of a row complete before the row advances.
- Exactly one bit of brightness_mask is set at all times after reset.
- Reset asserted in any state returns to the reset values on the next edge; OE goes high (dark) in that cycle.
- Cycle counts for one (row, plane) with defaults: 128 SHIFT + 1 BLANK + 1 LATCH + 4<<p DISPLAY.
  - Row total = 780 + 252 = 1032 cycles.
  - Frame total = 16512 cycles.

Test Plan:
- Reset then enable=1 -> busy=1 the next cycle. The first 128 cycles show 64 pixel_clock rising edges with column_address 0..63 and output_enable_n=1 throughout. Then BLANK, then row_latch=1 for exactly 1 cycle, then output_enable_n=0 for exactly 4 cycles with brightness_mask=6'b000001.
- Run one full row -> output_enable_n low-periods measure 4, 8, 16, 32, 64, 128 cycles with mask 1, 2, 4, 8, 16, 32 respectively. row_address stays 0 until the BLANK following plane 5, then becomes 1.
- Hold enable=1 for two frames -> frame_done pulses exactly once per 16512 cycles. After the pulse row_address=0 and mask=1, with no IDLE gap between frames.
- Drop enable at cycle 5000 of a frame -> the frame completes (frame_done at cycle 16512), then the block enters IDLE with busy=0, output_enable_n=1 and all strobes low.
- Assert reset during DISPLAY of plane 3, row 7 -> the next cycle shows all reset values (output_enable_n=1, row_address=0, mask=1). Re-enable restarts from row 0, plane 0.
- Protocol checker over a full frame:
  - row_address changes only while output_enable_n=1;
  - row_latch and output_enable_n=0 are never simultaneous;
  - pixel_clock is never high outside SHIFT;
  - brightness_mask is always one-hot.

Source files
------------

// File: rtl/bcm_scan_controller_if.sv
// Panel-side bundle of the BCM scan controller: run request in, framebuffer
// addressing, brightness plane select and HUB75 control strobes out.
interface bcm_scan_controller_if #(
  parameter int PIXELS_PER_ROW = 64,
  parameter int SCAN_ROWS      = 16,
  parameter int BITPLANES      = 6
);
  localparam int COL_W = $clog2(PIXELS_PER_ROW);
  localparam int ROW_W = $clog2(SCAN_ROWS);

  logic                 enable;
  logic [COL_W-1:0]     column_address;
  logic [ROW_W-1:0]     row_address;
  logic [BITPLANES-1:0] brightness_mask;
  logic [2:0]           rgb_enable;
  logic                 pixel_clock;
  logic                 row_latch;
  logic                 output_enable_n;
  logic                 busy;
  logic                 frame_done;

  // Controller side.
  modport master (
    input  enable,
    output column_address, row_address, brightness_mask, rgb_enable,
    output pixel_clock, row_latch, output_enable_n, busy, frame_done
  );

  // Requester / panel side.
  modport slave (
    output enable,
    input  column_address, row_address, brightness_mask, rgb_enable,
    input  pixel_clock, row_latch, output_enable_n, busy, frame_done
  );
endinterface

// File: rtl/bcm_scan_controller.sv
// Binary-coded-modulation scan sequencer for a HUB75 panel. For every scan
// row it walks the bit planes LSB first: shift a row of pixels, blank, latch,
// then hold OE low for BASE_ON_CYCLES << plane cycles. All outputs come
// straight from registers; the combinational block computes their next values.
module bcm_scan_controller #(
  parameter int PIXELS_PER_ROW = 64,
  parameter int SCAN_ROWS      = 16,
  parameter int BITPLANES      = 6,
  parameter int BASE_ON_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  bcm_scan_controller_if.master        bus
);

  localparam int COL_W   = $clog2(PIXELS_PER_ROW);
  localparam int ROW_W   = $clog2(SCAN_ROWS);
  localparam int PLANE_W = (BITPLANES > 1) ? $clog2(BITPLANES) : 1;
  localparam int CNT_W   = $clog2(BASE_ON_CYCLES << (BITPLANES - 1)) + 1;

  localparam logic [COL_W-1:0]     COL_LAST   = COL_W'(PIXELS_PER_ROW - 1);
  localparam logic [ROW_W-1:0]     ROW_LAST   = ROW_W'(SCAN_ROWS - 1);
  localparam logic [PLANE_W-1:0]   PLANE_LAST = PLANE_W'(BITPLANES - 1);
  localparam logic [BITPLANES-1:0] MASK_P0    = BITPLANES'(1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH,
    DISPLAY
  } state_t;

  state_t               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [ROW_W-1:0]     scan_row_q, scan_row_d;
  logic [ROW_W-1:0]     row_addr_q, row_addr_d;
  logic [PLANE_W-1:0]   plane_q, plane_d;
  logic [BITPLANES-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           rgb_q, rgb_d;
  logic                 pclk_q, pclk_d;
  logic                 latch_q, latch_d;
  logic                 oe_n_q, oe_n_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;

  // Display length of a plane, minus one, as loaded into the down-counter.
  // The counter then reaches zero on the final lit cycle.
  function automatic logic [CNT_W-1:0] on_time_last(input logic [PLANE_W-1:0] p);
    return CNT_W'((BASE_ON_CYCLES << p) - 1);
  endfunction

  // Next-state and next-output logic; registered outputs describe the state
  // being entered, so each branch sets what that next state must show.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    col_d        = col_q;
    scan_row_d   = scan_row_q;
    row_addr_d   = row_addr_q;
    plane_d      = plane_q;
    mask_d       = mask_q;
    cnt_d        = cnt_q;
    rgb_d        = 3'b000;
    pclk_d       = 1'b0;
    latch_d      = 1'b0;
    oe_n_d       = 1'b1;
    busy_d       = 1'b1;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        phase_d = 1'b0;
        col_d   = '0;
        busy_d  = 1'b0;
        if (bus.enable) begin
          state_d = SHIFT;
          busy_d  = 1'b1;
          rgb_d   = 3'b111;
        end
      end

      SHIFT: begin
        rgb_d = 3'b111;
        if (!phase_q) begin
          phase_d = 1'b1;
          pclk_d  = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q == COL_LAST) begin
            // Row fully shifted: go dark and only now move the row select.
            col_d      = '0;
            state_d    = BLANK;
            rgb_d      = 3'b000;
            row_addr_d = scan_row_q;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end

      BLANK: begin
        state_d = LATCH;
        latch_d = 1'b1;
      end

      LATCH: begin
        state_d = DISPLAY;
        oe_n_d  = 1'b0;
        cnt_d   = on_time_last(plane_q);
      end

      DISPLAY: begin
        if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          oe_n_d = 1'b0;
        end else begin
          state_d = SHIFT;
          rgb_d   = 3'b111;
          if (plane_q == PLANE_LAST) begin
            plane_d = '0;
            mask_d  = MASK_P0;
            if (scan_row_q == ROW_LAST) begin
              // Frame end: row select returns to 0 while the panel is dark,
              // and enable decides between another frame and idling.
              scan_row_d   = '0;
              row_addr_d   = '0;
              frame_done_d = 1'b1;
              if (!bus.enable) begin
                state_d = IDLE;
                rgb_d   = 3'b000;
                busy_d  = 1'b0;
              end
            end else begin
              scan_row_d = scan_row_q + 1'b1;
            end
          end else begin
            plane_d = plane_q + 1'b1;
            mask_d  = mask_q << 1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and control/output register; reset forces a dark, idle panel.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      phase_q      <= 1'b0;
      col_q        <= '0;
      scan_row_q   <= '0;
      row_addr_q   <= '0;
      plane_q      <= '0;
      mask_q       <= MASK_P0;
      rgb_q        <= 3'b000;
      pclk_q       <= 1'b0;
      latch_q      <= 1'b0;
      oe_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      col_q        <= col_d;
      scan_row_q   <= scan_row_d;
      row_addr_q   <= row_addr_d;
      plane_q      <= plane_d;
      mask_q       <= mask_d;
      rgb_q        <= rgb_d;
      pclk_q       <= pclk_d;
      latch_q      <= latch_d;
      oe_n_q       <= oe_n_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // On-time down-counter; always loaded in LATCH before use, so no reset.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign bus.column_address  = col_q;
  assign bus.row_address     = row_addr_q;
  assign bus.brightness_mask = mask_q;
  assign bus.rgb_enable      = rgb_q;
  assign bus.pixel_clock     = pclk_q;
  assign bus.row_latch       = latch_q;
  assign bus.output_enable_n = oe_n_q;
  assign bus.busy            = busy_q;
  assign bus.frame_done      = frame_done_q;

endmodule

// File: tb/tb_bcm_scan_controller.sv
// Bench for bcm_scan_controller: a frame-position model predicts every output
// each cycle, and directed sequences pin row timing, frame length, enable
// drop and reset recovery with literal values.
module tb_bcm_scan_controller;

  localparam int PPR  = 64;
  localparam int SR   = 16;
  localparam int BP   = 6;
  localparam int BASE = 4;
  localparam int SHIFT_CYC = 2 * PPR;

  function automatic int seg_len(input int p);
    return SHIFT_CYC + 2 + (BASE << p);
  endfunction

  function automatic int row_len();
    int s;
    s = 0;
    for (int p = 0; p < BP; p++) s += seg_len(p);
    return s;
  endfunction

  localparam int ROW_CYC   = row_len();
  localparam int FRAME_CYC = ROW_CYC * SR;

  typedef struct packed {
    logic [5:0] col;
    logic [3:0] row;
    logic [5:0] mask;
    logic [2:0] rgb;
    logic       pclk;
    logic       latch;
    logic       oe_n;
    logic       busy;
    logic       fd;
  } obs_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  bit   chk_en;

  bcm_scan_controller_if #(.PIXELS_PER_ROW(PPR), .SCAN_ROWS(SR), .BITPLANES(BP)) bus ();

  bcm_scan_controller #(
    .PIXELS_PER_ROW(PPR),
    .SCAN_ROWS     (SR),
    .BITPLANES     (BP),
    .BASE_ON_CYCLES(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected outputs from the frame position: which row, which plane, and
  // the offset inside that plane's shift/blank/latch/display slot.
  function automatic obs_t model_at(input bit run, input int pos, input bit fd);
    obs_t e;
    int   r, off, p;
    e = '{col: 6'd0, row: 4'd0, mask: 6'd1, rgb: 3'd0, pclk: 1'b0,
          latch: 1'b0, oe_n: 1'b1, busy: 1'b0, fd: fd};
    if (!run) return e;
    e.busy = 1'b1;
    r   = pos / ROW_CYC;
    off = pos % ROW_CYC;
    p   = 0;
    while (p < BP - 1 && off >= seg_len(p)) begin
      off -= seg_len(p);
      p++;
    end
    e.mask = 6'(1 << p);
    if (p == 0 && off <= SHIFT_CYC - 1) e.row = 4'((r > 0) ? r - 1 : 0);
    else                                e.row = 4'(r);
    if (off < SHIFT_CYC) begin
      e.rgb  = 3'b111;
      e.col  = 6'(off / 2);
      e.pclk = 1'(off % 2);
    end else if (off == SHIFT_CYC + 1) begin
      e.latch = 1'b1;
    end else if (off > SHIFT_CYC + 1) begin
      e.oe_n = 1'b0;
    end
    return e;
  endfunction

  // Model of the run/idle behaviour as seen at each clock edge.
  bit m_run;
  int m_pos;
  bit m_fd;
  initial begin
    m_run = 1'b0;
    m_pos = 0;
    m_fd  = 1'b0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_run <= 1'b0;
      m_pos <= 0;
      m_fd  <= 1'b0;
    end else if (!m_run) begin
      m_fd <= 1'b0;
      if (bus.enable) begin
        m_run <= 1'b1;
        m_pos <= 0;
      end
    end else if (m_pos == FRAME_CYC - 1) begin
      m_fd  <= 1'b1;
      m_pos <= 0;
      m_run <= bus.enable;
    end else begin
      m_pos <= m_pos + 1;
      m_fd  <= 1'b0;
    end
  end

  // Per-cycle comparison against the model plus protocol rules.
  logic [3:0] prev_row;
  initial prev_row = 4'd0;
  always begin
    obs_t e;
    @(posedge clk);
    #1;
    if (chk_en) begin
      e = model_at(m_run, m_pos, m_fd);
      chk("col",   bus.column_address,  e.col);
      chk("row",   bus.row_address,     e.row);
      chk("mask",  bus.brightness_mask, e.mask);
      chk("rgb",   bus.rgb_enable,      e.rgb);
      chk("pclk",  bus.pixel_clock,     e.pclk);
      chk("latch", bus.row_latch,       e.latch);
      chk("oe_n",  bus.output_enable_n, e.oe_n);
      chk("busy",  bus.busy,            e.busy);
      chk("fdone", bus.frame_done,      e.fd);
      chk("row_change_dark", (bus.row_address != prev_row) && !bus.output_enable_n, 1'b0);
      chk("latch_while_lit", bus.row_latch && !bus.output_enable_n, 1'b0);
      chk("pclk_outside_shift", bus.pixel_clock && (bus.rgb_enable != 3'b111), 1'b0);
      chk("mask_onehot", $onehot(bus.brightness_mask), 1'b1);
    end
    prev_row = bus.row_address;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col"},   bus.column_address,  6'd0);
    chk({tag, "_row"},   bus.row_address,     4'd0);
    chk({tag, "_mask"},  bus.brightness_mask, 6'd1);
    chk({tag, "_rgb"},   bus.rgb_enable,      3'd0);
    chk({tag, "_pclk"},  bus.pixel_clock,     1'b0);
    chk({tag, "_latch"}, bus.row_latch,       1'b0);
    chk({tag, "_oe_n"},  bus.output_enable_n, 1'b1);
    chk({tag, "_busy"},  bus.busy,            1'b0);
    chk({tag, "_fdone"}, bus.frame_done,      1'b0);
  endtask

  // Walks one plane starting at its first SHIFT cycle and ends at the
  // first SHIFT cycle of the following plane.
  task automatic walk_plane(input int p, input logic [3:0] row_before, input logic [3:0] row_after);
    logic [5:0] mask_tab [6];
    int         on_tab   [6];
    int rises, col_bad, oe_bad, row_bad, on_len, m_bad;
    logic prev_pclk;
    mask_tab = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32};
    on_tab   = '{4, 8, 16, 32, 64, 128};
    rises = 0; col_bad = 0; oe_bad = 0; row_bad = 0; m_bad = 0;
    prev_pclk = 1'b0;
    for (int i = 0; i < SHIFT_CYC; i++) begin
      if (bus.pixel_clock && !prev_pclk) begin
        if (bus.column_address != 6'(rises)) col_bad++;
        rises++;
      end
      if (!bus.output_enable_n) oe_bad++;
      if (bus.row_address != row_before) row_bad++;
      prev_pclk = bus.pixel_clock;
      step();
    end
    chk("shift_rises", rises, PPR);
    chk("shift_cols", col_bad, 0);
    chk("shift_oe_lit", oe_bad, 0);
    chk("shift_row_held", row_bad, 0);
    chk("blank_rgb", bus.rgb_enable, 3'd0);
    chk("blank_oe_n", bus.output_enable_n, 1'b1);
    chk("blank_row", bus.row_address, row_after);
    step();
    chk("latch_strobe", bus.row_latch, 1'b1);
    step();
    chk("latch_one_cycle", bus.row_latch, 1'b0);
    on_len = 0;
    while (!bus.output_enable_n && on_len < 300) begin
      if (bus.brightness_mask != mask_tab[p]) m_bad++;
      on_len++;
      step();
    end
    chk("on_len", on_len, on_tab[p]);
    chk("on_mask", m_bad, 0);
  endtask

  initial begin
    int k;
    bit found;
    total  = 0;
    bad    = 0;
    chk_en = 1'b0;
    reset  = 1'b1;
    bus.enable = 1'b0;
    repeat (3) step();
    chk_en = 1'b1;
    chk_reset_vals("reset");
    reset = 1'b0;
    step();
    chk("idle_busy", bus.busy, 1'b0);

    // First row: plane timings and row select behaviour.
    bus.enable = 1'b1;
    step();
    chk("start_busy", bus.busy, 1'b1);
    chk("start_col", bus.column_address, 6'd0);
    chk("start_pclk", bus.pixel_clock, 1'b0);
    for (int p = 0; p < BP; p++) walk_plane(p, 4'd0, 4'd0);
    walk_plane(0, 4'd0, 4'd1);

    // Continuous frames: one pulse per frame and no idle gap.
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (bus.frame_done) found = 1'b1;
      else step();
    end
    chk("frame1_timeout", found, 1'b1);
    chk("fd_row", bus.row_address, 4'd0);
    chk("fd_mask", bus.brightness_mask, 6'd1);
    chk("fd_no_gap", bus.busy, 1'b1);
    k = 0;
    do begin step(); k++; end while (!bus.frame_done && k < 20000);
    chk("frame_period", k, 16512);

    // Enable dropped mid-frame: the frame still completes, then idle.
    k = 0;
    do begin
      step();
      k++;
      if (k == 5000) bus.enable = 1'b0;
    end while (!bus.frame_done && k < 20000);
    chk("drop_frame_period", k, 16512);
    chk("drop_busy", bus.busy, 1'b0);
    chk("drop_oe_n", bus.output_enable_n, 1'b1);
    chk("drop_strobes", {bus.pixel_clock, bus.row_latch, bus.rgb_enable}, 5'd0);
    step();
    chk("drop_idle_busy", bus.busy, 1'b0);
    chk("drop_idle_fd", bus.frame_done, 1'b0);

    // Reset during DISPLAY of plane 3 on row 7.
    bus.enable = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      if (bus.row_address == 4'd7 && bus.brightness_mask == 6'd8 && !bus.output_enable_n)
        found = 1'b1;
      else step();
    end
    chk("reach_r7p3", found, 1'b1);
    step();
    step();
    reset = 1'b1;
    bus.enable = 1'b0;
    step();
    chk_reset_vals("midreset");
    reset = 1'b0;
    step();
    bus.enable = 1'b1;
    k = 0;
    do begin step(); k++; end while (bus.output_enable_n && k < 400);
    chk("restart_to_lit", k, 131);
    chk("restart_mask", bus.brightness_mask, 6'd1);
    chk("restart_row", bus.row_address, 4'd0);
    k = 0;
    while (!bus.output_enable_n && k < 300) begin step(); k++; end
    chk("restart_on_len", k, 4);
    repeat (20) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
